cf_event_fifo: RTL
==================

// Module: cf_event_fifo
// PURPOSE
//  Downstream consumer of xyz: watches single-bit outputs signal_c (from u_abc) and
//  signal_f (from u_def), detects rising edges, timestamps each event and queues it
//  in a small show-ahead FIFO drained by a valid/ready sink (event logger / CSR block).
//  Sits in the same clock domain as xyz; no CDC.
// PARAMETERS
//  DEPTH   4  FIFO entries; power of two, >= 2
//  TS_W    8  timestamp counter width; wraps modulo 2**TS_W
// PORTS
//  clk         in   1        sole clock; all logic on posedge
//  rst_n       in   1        synchronous reset, active-low
//  signal_c    in   1        from xyz (u_abc output)
//  signal_f    in   1        from xyz (u_def output)
//  evt_valid   out  1        FIFO non-empty; evt_data is valid
//  evt_ready   in   1        sink accepts head entry this cycle
//  evt_data    out  TS_W+2   {src[1:0], ts[TS_W-1:0]} of head entry
//  evt_ovf     out  1        sticky: an event was dropped (FIFO full)
//  evt_level   out  clog2(DEPTH)+1  current occupancy
// BEHAVIOUR
//  Reset (rst_n==0 at posedge): evt_valid=0, evt_data=0, evt_ovf=0, evt_level=0,
//   ts=0, FIFO pointers=0, edge-history regs c_q=f_q=1 (no spurious event if input high).
//   Reset mid-operation flushes all queued entries; nothing is emitted afterwards.
//  Timestamp: ts increments every cycle out of reset, wraps 2**TS_W-1 -> 0.
//  Edge detect at posedge k: rc = signal_c & ~c_q, rf = signal_f & ~f_q; then c_q<=signal_c,
//   f_q<=signal_f. Falling edges ignored.
//  Event at edge k if rc|rf: src = {rf, rc} (01=c, 10=f, 11=both same cycle -> one entry);
//   ts field = ts value before the increment at edge k.
//  Latency: event at edge k into empty FIFO -> evt_valid=1, evt_data=entry after edge k.
//  Handshake: pop when evt_valid & evt_ready at posedge; evt_data/evt_valid must not change
//   while evt_valid & ~evt_ready (except reset). evt_ready while empty: no effect.
//  Push+pop same edge: both occur; level unchanged; order preserved.
//  Full (level==DEPTH): push with simultaneous pop is accepted; push without pop is dropped
//   and evt_ovf<=1 (stays 1 until reset). Full never corrupts stored entries.
//  Pointers wrap modulo DEPTH; level derived from extra-bit pointer difference.
//  evt_level is registered and reflects state after the most recent edge.
// CONFIGURATION
//  CF_EVENT_DROP_CNT_EN defined: adds output evt_drop_cnt [7:0] = count of dropped events,
//   saturating at 8'hFF, reset 0. Not defined: port absent, no counter; evt_ovf unchanged.
// TESTING
//  1 reset, hold signal_c=signal_f=1 for 10 cycles -> evt_valid stays 0, evt_level=0.
//  2 signal_c 0->1 at ts=5, evt_ready=1 -> evt_valid 1 cycle, evt_data={2'b01,8'd5}.
//  3 c and f rise same edge at ts=9 -> single entry {2'b11,8'd9}, evt_level peaks 1.
//  4 evt_ready=0, 5 c-edges -> 4 entries, 5th dropped, evt_ovf=1, drop_cnt=1 (if _EN);
//    then drain -> ts order preserved, evt_ovf remains 1.
//  5 full FIFO, edge with evt_ready=1 same cycle -> accepted, evt_level stays 4, evt_ovf 0.
//  6 3 entries queued, rst_n=0 one cycle -> evt_valid=0, level=0, ts restarts at 0.

Source files
------------

// File: rtl/cf_event_fifo.sv
// cf_event_fifo: timestamps rising edges of signal_c / signal_f and queues
// {src, ts} entries in a show-ahead FIFO drained by a valid/ready sink.
// Optional: define CF_EVENT_DROP_CNT_EN to add the evt_drop_cnt output
// (saturating count of events dropped while the FIFO was full).
module cf_event_fifo #(
    parameter int DEPTH = 4,
    parameter int TS_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    signal_c,
    input  logic                    signal_f,
    output logic                    evt_valid,
    input  logic                    evt_ready,
    output logic [TS_W+1:0]         evt_data,
    output logic                    evt_ovf,
    output logic [$clog2(DEPTH):0]  evt_level
`ifdef CF_EVENT_DROP_CNT_EN
    ,
    output logic [7:0]              evt_drop_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [TS_W+1:0] mem [DEPTH];
    logic [AW:0]     wr_ptr, rd_ptr, wr_nxt, rd_nxt;
    logic [TS_W-1:0] ts;
    logic            c_q, f_q;
    logic            rc, rf, push, pop, full, accept, drop;
    logic [TS_W+1:0] entry;

    // Edge detect and push/pop decisions for this edge
    always_comb begin
        rc     = signal_c & ~c_q;
        rf     = signal_f & ~f_q;
        push   = rc | rf;
        entry  = {rf, rc, ts};
        pop    = evt_valid & evt_ready;
        full   = (evt_level == LW'(DEPTH));
        // When full, a simultaneous pop frees the head slot, so the push fits
        accept = push & (~full | pop);
        drop   = push & full & ~pop;
        wr_nxt = accept ? wr_ptr + LW'(1) : wr_ptr;
        rd_nxt = pop    ? rd_ptr + LW'(1) : rd_ptr;
    end

    // Pointers, registered status, timestamp and edge history
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            evt_level <= '0;
            evt_valid <= 1'b0;
            evt_ovf   <= 1'b0;
            ts        <= '0;
            c_q       <= 1'b1;
            f_q       <= 1'b1;
        end else begin
            wr_ptr    <= wr_nxt;
            rd_ptr    <= rd_nxt;
            evt_level <= wr_nxt - rd_nxt;
            evt_valid <= (wr_nxt != rd_nxt);
            if (drop) evt_ovf <= 1'b1;
            ts        <= ts + TS_W'(1);
            c_q       <= signal_c;
            f_q       <= signal_f;
        end
    end

    // Storage array; contents need no reset since reads are gated by evt_valid
    always_ff @(posedge clk) begin
        if (rst_n && accept) mem[wr_ptr[AW-1:0]] <= entry;
    end

    // Show-ahead head entry; zero while empty
    always_comb begin
        evt_data = '0;
        if (evt_valid) evt_data = mem[rd_ptr[AW-1:0]];
    end

`ifdef CF_EVENT_DROP_CNT_EN
    // Saturating count of dropped events
    always_ff @(posedge clk) begin
        if (!rst_n)                        evt_drop_cnt <= 8'd0;
        else if (drop && evt_drop_cnt != 8'hFF) evt_drop_cnt <= evt_drop_cnt + 8'd1;
    end
`endif

endmodule
